// File: rtl/word_stream_tx_pkg.sv
// Shared types and constants for the word_stream_tx transmitter.
package word_stream_pkg;

  localparam int WORD_W  = 32;
  localparam int MAX_GAP = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/word_stream_tx_if.sv
// Producer/stream bundle for word_stream_tx; the master side pushes words, the slave is the transmitter.
interface word_stream_tx_if #(
  parameter int WIDTH = word_stream_pkg::WORD_W
);

  // Handshake: wr_en is a one-cycle push with no ready; it is accepted when full is low in that
  // same cycle, otherwise dropped and overflow latches. enable is a one-cycle strobe qualifying din,
  // with no backpressure from the receiver.
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             hold;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             busy;
  logic             enable;
  logic [WIDTH-1:0] din;

  modport master (
    output wr_en, wr_data, hold,
    input  full, empty, overflow, busy, enable, din
  );

  modport slave (
    input  wr_en, wr_data, hold,
    output full, empty, overflow, busy, enable, din
  );

endinterface

// File: rtl/word_stream_tx_sync_fifo.sv
// Small synchronous FIFO with a combinational head and the entry behind it for back-to-back reads.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [WIDTH-1:0]         rd_next,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign rd_next = mem_q[rd_ptr_q + AW'(1)];

  // full is judged on the pre-pop count, so a push during a pop while full is still rejected.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/word_stream_tx.sv
// Replays buffered words as one-cycle enable/din pulses separated by GAP idle cycles.
// Optional running-sum output enabled by defining WORD_STREAM_TX_CKSUM_EN.
module word_stream_tx
  import word_stream_pkg::tx_state_t;
  import word_stream_pkg::WORD_W;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 8,
  parameter int GAP   = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  word_stream_tx_if.slave   bus,
  output tx_state_t         dbg_state
`ifdef WORD_STREAM_TX_CKSUM_EN
  ,
  output logic [WIDTH-1:0]  cksum
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  tx_state_t        state_q, state_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             enable_q, enable_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] head, head_next;
  logic             full, empty, rd_en;
  logic [CW-1:0]    count;

  assign rd_en = (state_q == word_stream_pkg::SEND);

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (rd_en),
    .rd_data (head),
    .rd_next (head_next),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    din_d      = din_q;
    overflow_d = overflow_q | (bus.wr_en & full);

    case (state_q)
      word_stream_pkg::IDLE: begin
        if (!empty && !bus.hold) state_d = word_stream_pkg::SEND;
      end
      word_stream_pkg::SEND: begin
        if (GAP > 0) begin
          state_d   = word_stream_pkg::GAP;
          gap_cnt_d = GAP_LOAD;
        end else if ((count >= CW'(2)) && !bus.hold) begin
          state_d = word_stream_pkg::SEND;
        end else begin
          state_d = word_stream_pkg::IDLE;
        end
      end
      word_stream_pkg::GAP: begin
        if (gap_cnt_q != 4'd0) begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end else if (!empty && !bus.hold) begin
          state_d = word_stream_pkg::SEND;
        end else begin
          state_d = word_stream_pkg::IDLE;
        end
      end
      default: state_d = word_stream_pkg::IDLE;
    endcase

    // The current head is still in the FIFO during SEND, so a back-to-back pulse takes the next entry.
    enable_d = (state_d == word_stream_pkg::SEND);
    if (enable_d) din_d = (state_q == word_stream_pkg::SEND) ? head_next : head;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= word_stream_pkg::IDLE;
      gap_cnt_q  <= 4'd0;
      enable_q   <= 1'b0;
      din_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      enable_q   <= enable_d;
      din_q      <= din_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef WORD_STREAM_TX_CKSUM_EN
  logic [WIDTH-1:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (state_q == word_stream_pkg::SEND) cksum_d = cksum_q + din_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cksum_q <= '0;
    else        cksum_q <= cksum_d;
  end

  assign cksum = cksum_q;
`endif

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state_q != word_stream_pkg::IDLE) || !empty;
  assign bus.enable   = enable_q;
  assign bus.din      = din_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_word_stream_tx.sv
// Self-checking bench for word_stream_tx: dut_a runs with GAP=1, dut_b with GAP=0.
module tb_word_stream_tx;
  import word_stream_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  word_stream_tx_if #(.WIDTH(32)) bus_a ();
  word_stream_tx_if #(.WIDTH(32)) bus_b ();
  tx_state_t st_a, st_b;
`ifdef WORD_STREAM_TX_CKSUM_EN
  logic [31:0] cksum_a, cksum_b;
`endif

  word_stream_tx #(.WIDTH(32), .DEPTH(8), .GAP(1)) dut_a (
    .clk(clk), .n_rst(n_rst), .bus(bus_a), .dbg_state(st_a)
`ifdef WORD_STREAM_TX_CKSUM_EN
    , .cksum(cksum_a)
`endif
  );

  word_stream_tx #(.WIDTH(32), .DEPTH(8), .GAP(0)) dut_b (
    .clk(clk), .n_rst(n_rst), .bus(bus_b), .dbg_state(st_b)
`ifdef WORD_STREAM_TX_CKSUM_EN
    , .cksum(cksum_b)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] ea, eb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboards: every pulse must match the oldest word still expected.
  always @(negedge clk) begin
    if (n_rst && bus_a.enable) begin
      if (exp_a.size() == 0) chk("a_spurious_pulse", 32'd1, 32'd0);
      else begin
        ea = exp_a.pop_front();
        chk("a_word", bus_a.din, ea);
      end
    end
  end

  always @(negedge clk) begin
    if (n_rst && bus_b.enable) begin
      if (exp_b.size() == 0) chk("b_spurious_pulse", 32'd1, 32'd0);
      else begin
        eb = exp_b.pop_front();
        chk("b_word", bus_b.din, eb);
      end
    end
  end

  task automatic wait_pulse(input bit sel_b, input int max, input string tag);
    bit found = 1'b0;
    for (int k = 0; k < max && !found; k++) begin
      @(negedge clk);
      found = sel_b ? bus_b.enable : bus_a.enable;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic count_pulses(input bit sel_b, input int cycles, output int pc);
    pc = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (sel_b ? bus_b.enable : bus_a.enable) pc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] pat;
    logic [3:0] pat_b;
    int pc;

    n_rst = 1'b0;
    bus_a.wr_en = 1'b0; bus_a.wr_data = '0; bus_a.hold = 1'b0;
    bus_b.wr_en = 1'b0; bus_b.wr_data = '0; bus_b.hold = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("rst_enable",   32'(bus_a.enable), 32'd0);
    chk("rst_din",      bus_a.din, 32'd0);
    chk("rst_empty",    32'(bus_a.empty), 32'd1);
    chk("rst_full",     32'(bus_a.full), 32'd0);
    chk("rst_overflow", 32'(bus_a.overflow), 32'd0);
    chk("rst_busy",     32'(bus_a.busy), 32'd0);
    chk("rst_state",    32'(st_a), 32'(IDLE));

    // Reset while one word is out, FSM in GAP, three words still buffered.
    bus_a.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_a.wr_en = 1'b1; bus_a.wr_data = 32'hA0 + 32'(i);
      exp_a.push_back(32'hA0 + 32'(i));
    end
    @(negedge clk);
    bus_a.wr_en = 1'b0; bus_a.hold = 1'b0;
    wait_pulse(1'b0, 5, "mr_first_pulse");
    @(negedge clk);
    chk("mr_state_gap", 32'(st_a), 32'(GAP));
    chk("mr_not_empty", 32'(bus_a.empty), 32'd0);
    n_rst = 1'b0;
    exp_a.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    chk("mr_empty",    32'(bus_a.empty), 32'd1);
    chk("mr_din",      bus_a.din, 32'd0);
    chk("mr_overflow", 32'(bus_a.overflow), 32'd0);
    count_pulses(1'b0, 12, pc);
    chk("mr_no_pulse", 32'(pc), 32'd0);

`ifdef WORD_STREAM_TX_CKSUM_EN
    bus_b.hold = 1'b1;
    @(negedge clk); bus_b.wr_en = 1'b1; bus_b.wr_data = 32'hFFFF_FFFF; exp_b.push_back(32'hFFFF_FFFF);
    @(negedge clk); bus_b.wr_data = 32'h0000_0002; exp_b.push_back(32'h0000_0002);
    @(negedge clk); bus_b.wr_en = 1'b0; bus_b.hold = 1'b0;
    wait_pulse(1'b1, 5, "ck_first_pulse");
    @(negedge clk);
    chk("ck_partial", cksum_b, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("ck_final", cksum_b, 32'h0000_0001);
`endif

    // Single word latency.
    @(negedge clk);
    bus_a.wr_en = 1'b1; bus_a.wr_data = 32'h1234_ABCD; exp_a.push_back(32'h1234_ABCD);
    @(negedge clk);
    bus_a.wr_en = 1'b0;
    chk("s_e0_enable", 32'(bus_a.enable), 32'd0);
    @(negedge clk);
    chk("s_e1_enable", 32'(bus_a.enable), 32'd1);
    chk("s_e1_din",    bus_a.din, 32'h1234_ABCD);
    @(negedge clk);
    chk("s_e2_enable", 32'(bus_a.enable), 32'd0);
    chk("s_e2_busy",   32'(bus_a.busy), 32'd1);
    @(negedge clk);
    chk("s_e3_busy",   32'(bus_a.busy), 32'd0);
    chk("s_e3_din",    bus_a.din, 32'h1234_ABCD);

    // Four back-to-back pushes with GAP=1.
    fork
      begin
        for (int i = 1; i <= 4; i++) begin
          @(negedge clk);
          bus_a.wr_en = 1'b1; bus_a.wr_data = 32'(i); exp_a.push_back(32'(i));
        end
        @(negedge clk);
        bus_a.wr_en = 1'b0;
      end
      begin
        wait_pulse(1'b0, 10, "p_first_pulse");
        pat[0] = bus_a.enable;
        for (int k = 1; k < 7; k++) begin
          @(negedge clk);
          pat[k] = bus_a.enable;
        end
      end
    join
    chk("p_pattern", 32'(pat), 32'h55);
    repeat (3) @(negedge clk);
    chk("p_din_held", bus_a.din, 32'h4);
    chk("p_idle",     32'(bus_a.busy), 32'd0);

    // Fill past DEPTH while held.
    bus_a.hold = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 9) begin
        chk("o_full_after_8", 32'(bus_a.full), 32'd1);
        chk("o_no_overflow_yet", 32'(bus_a.overflow), 32'd0);
      end
      bus_a.wr_en = 1'b1; bus_a.wr_data = 32'h10 + 32'(i);
      if (i <= 8) exp_a.push_back(32'h10 + 32'(i));
    end
    @(negedge clk);
    bus_a.wr_en = 1'b0;
    chk("o_overflow", 32'(bus_a.overflow), 32'd1);
    chk("o_still_full", 32'(bus_a.full), 32'd1);
    bus_a.hold = 1'b0;
    count_pulses(1'b0, 40, pc);
    chk("o_pulse_count", 32'(pc), 32'd8);
    chk("o_drained", 32'(bus_a.empty), 32'd1);
    chk("o_sticky", 32'(bus_a.overflow), 32'd1);

    // GAP=0: three queued words go out on consecutive cycles.
    bus_b.hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      bus_b.wr_en = 1'b1; bus_b.wr_data = 32'hB0 + 32'(i); exp_b.push_back(32'hB0 + 32'(i));
    end
    @(negedge clk);
    bus_b.wr_en = 1'b0; bus_b.hold = 1'b0;
    wait_pulse(1'b1, 5, "g0_first_pulse");
    pat_b[3] = bus_b.enable;
    @(negedge clk); pat_b[2] = bus_b.enable;
    @(negedge clk); pat_b[1] = bus_b.enable;
    @(negedge clk); pat_b[0] = bus_b.enable;
    chk("g0_pattern", 32'(pat_b), 32'hE);

    // GAP=0: hold raised during the second pulse defers the third.
    bus_b.hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      bus_b.wr_en = 1'b1; bus_b.wr_data = 32'hC0 + 32'(i); exp_b.push_back(32'hC0 + 32'(i));
    end
    @(negedge clk);
    bus_b.wr_en = 1'b0; bus_b.hold = 1'b0;
    wait_pulse(1'b1, 5, "h_first_pulse");
    @(negedge clk);
    chk("h_second_pulse", 32'(bus_b.enable), 32'd1);
    bus_b.hold = 1'b1;
    @(negedge clk);
    chk("h_second_done", 32'(bus_b.enable), 32'd0);
    count_pulses(1'b1, 5, pc);
    chk("h_third_blocked", 32'(pc), 32'd0);
    chk("h_third_waiting", 32'(bus_b.empty), 32'd0);
    bus_b.hold = 1'b0;
    wait_pulse(1'b1, 5, "h_third_pulse");
    @(negedge clk);
    chk("h_after_third", 32'(bus_b.enable), 32'd0);
    chk("h_empty", 32'(bus_b.empty), 32'd1);

    repeat (4) @(negedge clk);
    chk("a_queue_drained", 32'(exp_a.size()), 32'd0);
    chk("b_queue_drained", 32'(exp_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
